// File: rtl/ex_mul_unit_pkg.sv
// Shared pipeline definitions for the EX-stage multiplier: FSM state
// encoding, default operand width, fixed latency and counter sizing.
package ex_mul_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Cycles from the start cycle to the first MUL_done cycle.
    localparam int unsigned MUL_LAT = XLEN_DEFAULT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Counter must hold the value XLEN itself, hence the extra bit.
    function automatic int unsigned mul_cnt_width(input int unsigned xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add multiplier datapath.
// Ports: clk, rst (sync, active-high); load_i latches a_i/b_i, clears the
// accumulator and loads count=XLEN; step_i performs one shift-add step;
// count_o is the remaining step count; acc_o is the running product.
module mul_shift_add_dp
    import ex_mul_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_i,
    input  logic                            step_i,
    input  logic [XLEN-1:0]                 a_i,
    input  logic [XLEN-1:0]                 b_i,
    output logic [mul_cnt_width(XLEN)-1:0]  count_o,
    output logic [XLEN-1:0]                 acc_o
);

    localparam int unsigned CNT_W = mul_cnt_width(XLEN);

    logic [XLEN-1:0]  mcand_q,  mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Next-state: load has priority over step; idle otherwise holds.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            count_d  = CNT_W'(XLEN);
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/ex_mul_unit.sv
// EX-stage iterative multiplier with a three-state control FSM.
// Ports: clk, rst (sync, active-high); EX_a/EX_b operands, EX_mul start
// request, EX_rd/EX_we destination info from D/EX; MEM_stall downstream
// hold; flush abort. MUL_busy (combinational) freezes the front end;
// MUL_done/MUL_result/MUL_rd/MUL_we present the finished multiply.
module ex_mul_unit
    import ex_mul_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] EX_a,
    input  logic [XLEN-1:0] EX_b,
    input  logic            EX_mul,
    input  logic [4:0]      EX_rd,
    input  logic            EX_we,
    input  logic            MEM_stall,
    input  logic            flush,
    output logic            MUL_busy,
    output logic            MUL_done,
    output logic [XLEN-1:0] MUL_result,
    output logic [4:0]      MUL_rd,
    output logic            MUL_we
);

    localparam int unsigned CNT_W = mul_cnt_width(XLEN);

    mul_state_e       state_q, state_d;
    logic             done_q,  done_d;
    logic             mul_we_q, mul_we_d;
    logic             we_lat_q, we_lat_d;
    logic [4:0]       rd_q,    rd_d;
    logic             load_c;
    logic             step_c;
    logic             busy_c;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  acc;

    mul_shift_add_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_c),
        .step_i  (step_c),
        .a_i     (EX_a),
        .b_i     (EX_b),
        .count_o (count),
        .acc_o   (acc)
    );

    // Next-state and strobes; flush overrides everything it touches.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        mul_we_d = 1'b0;
        we_lat_d = we_lat_q;
        rd_d     = rd_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        busy_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (EX_mul && !MEM_stall) begin
                    load_c   = 1'b1;
                    busy_c   = 1'b1;
                    we_lat_d = EX_we;
                    rd_d     = EX_rd;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                busy_c = 1'b1;
                step_c = 1'b1;
                // Last step: the counter hits zero on this edge.
                if (count == CNT_W'(1)) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    mul_we_d = we_lat_q;
                end
            end
            DONE: begin
                if (MEM_stall) begin
                    done_d   = 1'b1;
                    mul_we_d = mul_we_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            mul_we_d = 1'b0;
            we_lat_d = we_lat_q;
            rd_d     = rd_q;
            load_c   = 1'b0;
            step_c   = 1'b0;
            busy_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            mul_we_q <= 1'b0;
            we_lat_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            mul_we_q <= mul_we_d;
            we_lat_q <= we_lat_d;
            rd_q     <= rd_d;
        end
    end

    // Reset wins over a start request within the same cycle.
    assign MUL_busy   = busy_c && !rst;
    assign MUL_done   = done_q;
    assign MUL_we     = mul_we_q;
    assign MUL_rd     = rd_q;
    assign MUL_result = acc;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed + randomized self-checking bench for ex_mul_unit (XLEN=32).
module tb_ex_mul_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] EX_a;
    logic [XLEN-1:0] EX_b;
    logic            EX_mul;
    logic [4:0]      EX_rd;
    logic            EX_we;
    logic            MEM_stall;
    logic            flush;
    logic            MUL_busy;
    logic            MUL_done;
    logic [XLEN-1:0] MUL_result;
    logic [4:0]      MUL_rd;
    logic            MUL_we;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mul_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .EX_a       (EX_a),
        .EX_b       (EX_b),
        .EX_mul     (EX_mul),
        .EX_rd      (EX_rd),
        .EX_we      (EX_we),
        .MEM_stall  (MEM_stall),
        .flush      (flush),
        .MUL_busy   (MUL_busy),
        .MUL_done   (MUL_done),
        .MUL_result (MUL_result),
        .MUL_rd     (MUL_rd),
        .MUL_we     (MUL_we)
    );

    always #5 clk = ~clk;

    // Reference product: full-width arithmetic, then keep the low XLEN bits.
    function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] full;
        full = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        return full[XLEN-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mul, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [4:0] rd, input logic we, input logic stall, input logic fl);
        EX_mul = mul; EX_a = a; EX_b = b; EX_rd = rd; EX_we = we;
        MEM_stall = stall; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_noise(input logic mul);
        drive(mul, XLEN'($urandom()), XLEN'($urandom()), 5'($urandom()), 1'($urandom()), 1'b0, 1'b0);
    endtask

    // One full multiply starting this cycle, with nstall stall cycles in DONE.
    task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [4:0] rd, input logic we, input int nstall);
        logic [XLEN-1:0] exp;
        exp = ref_mul(a, b);
        drive(1'b1, a, b, rd, we, 1'b0, 1'b0);
        check("start_busy", {63'd0, MUL_busy}, 64'd1);
        tick();
        for (int i = 1; i <= int'(XLEN); i++) begin
            drive_noise(1'($urandom()));
            check("busy_phase", {62'd0, MUL_busy, MUL_done}, 64'd2);
            tick();
        end
        for (int i = 0; i <= nstall; i++) begin
            drive(1'b0, XLEN'($urandom()), XLEN'($urandom()), 5'($urandom()),
                  1'($urandom()), (i < nstall), 1'b0);
            check("done_flags", {61'd0, MUL_done, MUL_busy, MUL_we}, {61'd0, 1'b1, 1'b0, we});
            check("result", {32'd0, MUL_result}, {32'd0, exp});
            check("rd", {59'd0, MUL_rd}, {59'd0, rd});
            tick();
        end
    endtask

    task automatic idle_check(input logic [XLEN-1:0] exp_res);
        drive_noise(1'b0);
        check("idle_flags", {61'd0, MUL_done, MUL_busy, MUL_we}, 64'd0);
        check("idle_hold_result", {32'd0, MUL_result}, {32'd0, exp_res});
        tick();
    endtask

    initial begin
        logic [XLEN-1:0] ra, rb;
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        // Start request under reset must not raise busy.
        drive(1'b1, 32'd9, 32'd9, 5'd3, 1'b1, 1'b0, 1'b0);
        check("rst_busy", {63'd0, MUL_busy}, 64'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("reset_outputs", {MUL_result, 23'd0, MUL_rd, MUL_we, MUL_done, MUL_busy}, 64'd0);
        tick();

        // Directed operands, including signed wrap-around cases.
        run_mul(32'd7, 32'd6, 5'd9, 1'b1, 0);
        idle_check(32'd42);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 0);
        idle_check(32'h0000_0001);
        run_mul(32'hFFFF_FFFD, 32'd5, 5'd31, 1'b0, 0);
        idle_check(32'hFFFF_FFF1);

        // Stall in DONE for three cycles.
        run_mul(32'd1234, 32'd5678, 5'd17, 1'b1, 3);
        idle_check(ref_mul(32'd1234, 32'd5678));

        // Back-to-back with no gap cycle.
        run_mul(32'd3, 32'd4, 5'd4, 1'b1, 0);
        run_mul(32'd5, 32'd5, 5'd5, 1'b1, 0);
        idle_check(32'd25);

        // Flush at T+10: busy drops that cycle, no result ever.
        drive(1'b1, 32'd11, 32'd13, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            drive_noise(1'b0);
            tick();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("flush_busy", {63'd0, MUL_busy}, 64'd0);
        tick();
        for (int i = 0; i < 40; i++) begin
            drive_noise(1'b0);
            check("post_flush", {62'd0, MUL_done, MUL_busy}, 64'd0);
            tick();
        end
        // Flush coinciding with a start request: no start.
        drive(1'b1, 32'd2, 32'd2, 5'd2, 1'b1, 1'b0, 1'b1);
        check("flush_vs_start", {63'd0, MUL_busy}, 64'd0);
        tick();
        drive_noise(1'b0);
        check("no_start_after_flush", {62'd0, MUL_busy, MUL_done}, 64'd0);
        tick();
        run_mul(32'd100, 32'd200, 5'd8, 1'b1, 0);

        // Reset at T+20 mid-operation.
        drive(1'b1, 32'd21, 32'd22, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < 20; i++) begin
            drive_noise(1'b0);
            tick();
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_busy", {63'd0, MUL_busy}, 64'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_outputs", {MUL_result, 23'd0, MUL_rd, MUL_we, MUL_done, MUL_busy}, 64'd0);
        tick();
        for (int i = 0; i < 40; i++) begin
            drive_noise(1'b0);
            check("post_rst", {62'd0, MUL_done, MUL_busy}, 64'd0);
            tick();
        end

        // Randomized operands, destinations and stall lengths.
        for (int k = 0; k < 8; k++) begin
            ra = XLEN'($urandom());
            rb = XLEN'($urandom());
            run_mul(ra, rb, 5'($urandom()), 1'($urandom()), int'($urandom_range(0, 2)));
        end
        idle_check(ref_mul(ra, rb));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mul_unit.md
EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 EX_a  input  XLEN  multiplicand, taken from the D/EX register output.
REQ-005 EX_b  input  XLEN  multiplier, taken from the D/EX register output.
REQ-006 EX_mul  input  1  the instruction in EX is a multiply.
REQ-007 EX_rd  input  5  destination register of the instruction in EX.
REQ-008 EX_we  input  1  register write-enable of the instruction in EX.
REQ-009 MEM_stall  input  1  downstream hold; no start is allowed and DONE is held while high.
REQ-010 flush  input  1  aborts the in-flight multiply; no result is produced.
REQ-011 MUL_busy  output  1  hold request to the front end; freezes the D/EX register and upstream stages.
REQ-012 MUL_done  output  1  one-cycle result-valid strobe, stretched while MEM_stall is high.
REQ-013 MUL_result  output  XLEN  low XLEN bits of EX_a*EX_b.
REQ-014 MUL_rd  output  5  EX_rd latched at start.
REQ-015 MUL_we  output  1  EX_we latched at start, gated so it is high only while MUL_done is high.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 Start condition: state IDLE and EX_mul=1 and MEM_stall=0 and flush=0, sampled in cycle T.
REQ-018 On start, the block SHALL latch EX_a, EX_b, EX_rd and EX_we, clear the accumulator, load count=XLEN, and move to BUSY.
REQ-019 MUL_busy SHALL be combinational and high in the start cycle T and in every BUSY cycle.
REQ-020 MUL_busy SHALL be low in IDLE (when not starting) and in DONE.
REQ-021 Each BUSY cycle SHALL perform one radix-2 shift-add step:
- if multiplier LSB=1, accumulator += multiplicand;
- multiplicand shifts left 1;
- multiplier shifts right 1;
- count decrements.
REQ-022 Arithmetic SHALL be modulo 2^XLEN with no overflow flag; the low bits are correct for both signed and unsigned operands.
REQ-023 When count reaches 0, BUSY SHALL transition to DONE. Fixed latency: MUL_done first high in cycle T+XLEN+1, and BUSY spans exactly XLEN cycles.
REQ-024 In DONE with MEM_stall=0, the FSM SHALL assert MUL_done for one cycle and return to IDLE.
REQ-025 In DONE with MEM_stall=1, the FSM SHALL remain in DONE and hold MUL_result, MUL_rd and MUL_we stable.
REQ-026 Because MUL_busy is low in DONE, the D/EX register advances there, so EX_mul=1 seen in IDLE the following cycle is a new instruction. Back-to-back multiplies SHALL start without a gap cycle.
REQ-027 flush=1 in any state SHALL force IDLE next cycle, suppress MUL_done and MUL_we, and deassert MUL_busy in that same cycle.
REQ-028 flush and start in the same cycle: flush wins and no start occurs.
REQ-029 EX_a, EX_b and EX_mul changes during BUSY SHALL be ignored; only the latched operands are used.
REQ-030 MUL_result SHALL hold its last value in IDLE and is meaningful only while MUL_done=1.

Reset
REQ-031 rst=1 SHALL force, at the next edge:
- state IDLE;
- count 0, accumulator 0, MUL_result 0, MUL_rd 0, MUL_we 0, MUL_done 0.
REQ-032 MUL_busy SHALL read 0 during any cycle in which rst=1.
REQ-033 rst SHALL take priority over flush, start and MEM_stall, including mid-operation; no result emerges afterwards.

Structure
REQ-034 The shared pipeline package SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the latency constant MUL_LAT=XLEN+1.
REQ-035 One sub-module, mul_shift_add_dp, SHALL hold the accumulator, shift registers and counter, controlled by load and step strobes from the FSM in ex_mul_unit.
REQ-036 Count width SHALL be $clog2(XLEN)+1.

Verification
REQ-037 EX_a=7, EX_b=6, start at T -> MUL_busy high T..T+32, MUL_done=1 at T+33, MUL_result=42, MUL_rd=EX_rd.
REQ-038 EX_a=EX_b=0xFFFFFFFF -> MUL_result=0x00000001; EX_a=-3 (0xFFFFFFFD), EX_b=5 -> 0xFFFFFFF1.
REQ-039 MEM_stall high for 3 cycles at T+33 -> MUL_done high 4 cycles with stable result and MUL_we high; IDLE afterwards.
REQ-040 flush at T+10 -> MUL_busy low at T+10, no MUL_done ever; next start behaves normally.
REQ-041 rst at T+20 -> all outputs 0 at the next edge, no MUL_done.
REQ-042 Two consecutive multiplies (3*4, then 5*5) -> results 12 then 25, MUL_done at T+33 and T+67.
